// File: rtl/sub_serial_32bit.sv
// sub_serial_32bit: bit-serial subtractor with valid/ready handshakes; SUB_SERIAL_DUAL_BIT_EN processes two bits per cycle
module sub_serial_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             borrowin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             borrowout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SUB_SERIAL_DUAL_BIT_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b;
  logic [CW-1:0] cnt;
  logic carry, c_msb_in, c_out, last;
  logic [STEP-1:0] s;
`ifdef SUB_SERIAL_DUAL_BIT_EN
  logic c_lo;
  assign s[0]     = a[0] ^ b[0] ^ carry;
  assign c_lo     = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
  assign s[1]     = a[1] ^ b[1] ^ c_lo;
  assign c_out    = (a[1] & b[1]) | (a[1] & c_lo) | (b[1] & c_lo);
  assign c_msb_in = c_lo;
`else
  assign s        = a[0] ^ b[0] ^ carry;
  assign c_out    = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
  assign c_msb_in = carry;
`endif
  assign last      = cnt == CW'(WIDTH - STEP);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid)  state_nx = RUN;
    if (state == RUN && last)       state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  // subtraction as num1 + ~num2 + ~borrowin; carry out of the MSB means no borrow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      D         <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a     <= num1;
      b     <= ~num2;
      carry <= ~borrowin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a     <= a >> STEP;
      b     <= b >> STEP;
      carry <= c_out;
      cnt   <= cnt + CW'(STEP);
      D     <= {s, D[WIDTH-1:STEP]};
      if (last) begin
        borrowout <= ~c_out;
        overflow  <= c_msb_in ^ c_out;
      end
    end
  end
endmodule

// File: tb/tb_sub_serial_32bit.sv
// tb_sub_serial_32bit: randomized and directed checks of sub_serial_32bit against an arithmetic reference model
module tb_sub_serial_32bit;
  localparam int W = 32;
`ifdef SUB_SERIAL_DUAL_BIT_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif
  localparam int BOUND = 4 * W;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, borrowin = 1'b0;
  logic in_ready, out_valid, borrowout, overflow;
  logic [W-1:0] num1 = '0, num2 = '0, d;
  int tests = 0, fails = 0;
  sub_serial_32bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .borrowin(borrowin), .out_valid(out_valid),
    .out_ready(out_ready), .D(d), .borrowout(borrowout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [W+1:0] model(input logic [W-1:0] n1, n2, input logic bin);
    logic [W:0] u;
    longint sd, lim;
    u   = {1'b0, n1} - {1'b0, n2} - {{W{1'b0}}, bin};
    sd  = longint'($signed(n1)) - longint'($signed(n2)) - longint'(bin);
    lim = longint'(1) <<< (W - 1);
    return {(sd >= lim) || (sd < -lim), u[W], u[W-1:0]};
  endfunction
  task automatic issue(input logic [W-1:0] n1, n2, input logic bin, output int lat,
                       output logic [W+1:0] got);
    num1 = n1; num2 = n2; borrowin = bin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    got = {overflow, borrowout, d};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, d, borrowout, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 2'b00}) begin
      fails++;
      $display("FAIL reset: got rdy=%b vld=%b D=%h bo=%b ov=%b, expected rdy=1 vld=0 D=0 bo=0 ov=0",
               in_ready, out_valid, d, borrowout, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_directed;
    logic [W-1:0] n1 [5] = '{32'd1120, 32'd0, 32'd8848, 32'h8000_0000, 32'd1024};
    logic [W-1:0] n2 [5] = '{32'd540, 32'd1, 32'd8848, 32'd1, 32'hFFFF_FE00};
    logic         bi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] ex [5] = '{{2'b00, 32'd580}, {2'b01, 32'hFFFF_FFFF}, {2'b01, 32'hFFFF_FFFF},
                             {2'b10, 32'h7FFF_FFFF}, {2'b01, 32'd1536}};
    logic [W+1:0] got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(n1[i], n2[i], bi[i], lat, got);
      tests += 2;
      if (got !== ex[i]) begin
        fails++;
        $display("FAIL directed%0d: got ov,bo,D=%h expected %h", i, got, ex[i]);
      end
      if (lat !== LAT) begin
        fails++;
        $display("FAIL latency%0d: got %0d expected %0d", i, lat, LAT);
      end
    end
  endtask
  task automatic test_random;
    logic [W-1:0] n1, n2;
    logic [W+1:0] got, ex;
    logic bin;
    int lat;
    for (int i = 0; i < 40; i++) begin
      n1  = (i % 5 == 0) ? 32'h8000_0000 : (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
      n2  = (i % 6 == 0) ? n1 : $urandom;
      bin = 1'($urandom);
      ex  = model(n1, n2, bin);
      issue(n1, n2, bin, lat, got);
      tests += 2;
      if (got !== ex) begin
        fails++;
        $display("FAIL random%0d %h-%h-%b: got ov,bo,D=%h expected %h", i, n1, n2, bin, got, ex);
      end
      if (lat !== LAT) begin
        fails++;
        $display("FAIL random_latency%0d: got %0d expected %0d", i, lat, LAT);
      end
    end
  endtask
  task automatic test_backpressure;
    logic [W+1:0] ex;
    int lat;
    ex = model(32'd5000, 32'd77, 1'b1);
    num1 = 32'd5000; num2 = 32'd77; borrowin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if ({overflow, borrowout, d} !== ex) begin
      fails++;
      $display("FAIL bp_result: got %h expected %h", {overflow, borrowout, d}, ex);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        num1 = $urandom; num2 = $urandom; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if ({out_valid, in_ready, overflow, borrowout, d} !== {2'b10, ex}) begin
        fails++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=%h",
                 i, out_valid, in_ready, {overflow, borrowout, d}, ex);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid, overflow, borrowout, d} !== {2'b10, ex}) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=%h",
               in_ready, out_valid, {overflow, borrowout, d}, ex);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_idle: got rdy=%b expected 1", in_ready);
    end
  endtask
  task automatic test_back_to_back;
    logic [W+1:0] exa, exb, got;
    int n, lat;
    exa = model(32'd300, 32'd1000, 1'b0);
    exb = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    out_ready = 1'b1;
    num1 = 32'd300; num2 = 32'd1000; borrowin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    num1 = 32'hDEAD_BEEF; num2 = 32'h1234_5678; borrowin = 1'b1;
    n = 0;
    got = '0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
      if (out_valid) got = {overflow, borrowout, d};
    end
    tests += 2;
    if (n !== LAT + 1) begin
      fails++;
      $display("FAIL b2b_period: got %0d expected %0d", n + 1, LAT + 2);
    end
    if (got !== exa) begin
      fails++;
      $display("FAIL b2b_first: got %h expected %h", got, exa);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if ({overflow, borrowout, d} !== exb) begin
      fails++;
      $display("FAIL b2b_second: got %h expected %h", {overflow, borrowout, d}, exb);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset_mid_run;
    logic [W+1:0] got;
    int lat;
    num1 = 32'hFFFF_0000; num2 = 32'd3; borrowin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, d, borrowout, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 2'b00}) begin
      fails++;
      $display("FAIL mid_reset: got rdy=%b vld=%b D=%h bo=%b ov=%b, expected rdy=1 vld=0 D=0 bo=0 ov=0",
               in_ready, out_valid, d, borrowout, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd100, 32'd200, 1'b0, lat, got);
    tests++;
    if (got !== {2'b01, 32'hFFFF_FF9C}) begin
      fails++;
      $display("FAIL after_reset: got %h expected %h", got, {2'b01, 32'hFFFF_FF9C});
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
